// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
//
// Round-robin arbiter that shares one word-wide RAM port between NREQ
// cache-side requesters. One requester owns the port at a time; its word
// accesses are forwarded to RAM and each completed access (ramstate == ACCESS)
// is reported back by dropping that requester's wait for one cycle. A grant is
// held across block transfers until the requester lets go or MAXBEATS words
// have completed, then the grant rotates.
//
// Ports
//   CLK, RST          : rising-edge clock, synchronous active-high reset
//   req_ren/req_wen   : per-requester read/write request levels (write wins)
//   req_addr/req_store: per-requester word address / write data
//   req_wait          : 1 = not served this cycle, 0 on the completing cycle
//   req_load          : read data to the served reader, 0 everywhere else
//   ramREN/ramWEN     : RAM read/write enables
//   ramaddr/ramstore  : RAM address / write data
//   ramload, ramstate : RAM read data and access status
// -----------------------------------------------------------------------------
package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAXBEATS = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req_ren,
    input  logic [NREQ-1:0]       req_wen,
    input  logic [NREQ-1:0][31:0] req_addr,
    input  logic [NREQ-1:0][31:0] req_store,
    output logic [NREQ-1:0]       req_wait,
    output logic [NREQ-1:0][31:0] req_load,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  ramstate_t             ramstate
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAXBEATS) + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    arb_state_t        state_r;
    logic [PW-1:0]     owner_r;
    logic [PW-1:0]     rr_ptr_r;
    logic [BW-1:0]     beats_r;

    arb_state_t        state_nxt_s;
    logic [PW-1:0]     owner_nxt_s;
    logic [PW-1:0]     rr_ptr_nxt_s;
    logic [BW-1:0]     beats_nxt_s;

    logic [NREQ-1:0]   active_s;
    logic              owner_active_s;
    logic              owner_write_s;
    logic              access_done_s;
    logic              any_active_s;
    logic [PW-1:0]     winner_s;
    logic [PW-1:0]     owner_inc_s;
    int                idx_s;

    // Request decode: who is asking, and whether the owner's access completes now.
    always_comb begin
        active_s       = req_ren | req_wen;
        owner_active_s = 1'b0;
        owner_write_s  = 1'b0;
        if (state_r == ST_OWN) begin
            owner_active_s = active_s[owner_r];
            owner_write_s  = req_wen[owner_r];
        end else begin
            owner_active_s = 1'b0;
            owner_write_s  = 1'b0;
        end
        // An owner that dropped its request this cycle gets no completion,
        // even if the RAM happens to report ACCESS.
        access_done_s = owner_active_s && (ramstate == ACCESS);
        owner_inc_s   = (owner_r == PW'(NREQ - 1)) ? '0 : (owner_r + PW'(1));
    end

    // Round-robin search: first active index starting at rr_ptr, wrapping mod NREQ.
    always_comb begin
        winner_s     = '0;
        any_active_s = 1'b0;
        idx_s        = 0;
        // Scan from the far end so the index closest to rr_ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx_s = (int'(rr_ptr_r) + k) % NREQ;
            if (active_s[idx_s]) begin
                winner_s     = PW'(idx_s);
                any_active_s = 1'b1;
            end else begin
                any_active_s = any_active_s;
            end
        end
    end

    // Next-state logic for grant, rotation pointer and beat count.
    always_comb begin
        state_nxt_s  = state_r;
        owner_nxt_s  = owner_r;
        rr_ptr_nxt_s = rr_ptr_r;
        beats_nxt_s  = beats_r;
        case (state_r)
            ST_IDLE: begin
                if (any_active_s) begin
                    state_nxt_s = ST_OWN;
                    owner_nxt_s = winner_s;
                    beats_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!owner_active_s) begin
                    state_nxt_s  = ST_IDLE;
                    rr_ptr_nxt_s = owner_inc_s;
                    beats_nxt_s  = '0;
                end else if (access_done_s) begin
                    if ((beats_r + BW'(1)) == BW'(MAXBEATS)) begin
                        // Beat limit reached: hand the port to someone else.
                        state_nxt_s  = ST_IDLE;
                        rr_ptr_nxt_s = owner_inc_s;
                        beats_nxt_s  = '0;
                    end else begin
                        beats_nxt_s = beats_r + BW'(1);
                    end
                end else begin
                    state_nxt_s = ST_OWN;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                owner_nxt_s  = '0;
                rr_ptr_nxt_s = '0;
                beats_nxt_s  = '0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            owner_r  <= '0;
            rr_ptr_r <= '0;
            beats_r  <= '0;
        end else begin
            state_r  <= state_nxt_s;
            owner_r  <= owner_nxt_s;
            rr_ptr_r <= rr_ptr_nxt_s;
            beats_r  <= beats_nxt_s;
        end
    end

    // Output steering: forward the owner's access and report its completion.
    always_comb begin
        req_wait = '1;
        req_load = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'h0000_0000;
        ramstore = 32'h0000_0000;
        if (owner_active_s) begin
            ramaddr = req_addr[owner_r];
            if (owner_write_s) begin
                ramWEN   = 1'b1;
                ramstore = req_store[owner_r];
            end else begin
                ramREN = 1'b1;
            end
            if (access_done_s) begin
                req_wait[owner_r] = 1'b0;
                if (!owner_write_s) begin
                    req_load[owner_r] = ramload;
                end else begin
                    req_load[owner_r] = 32'h0000_0000;
                end
            end else begin
                req_wait[owner_r] = 1'b1;
            end
        end else begin
            ramaddr = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_arbiter
//
// Bench for ram_arbiter. A behavioural model (current grant holder, search
// start and completed-word count) predicts every output on every cycle;
// directed scenarios add hand-computed expectations on top.
// -----------------------------------------------------------------------------
module tb_ram_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ     = 4;
    localparam int MAXBEATS = 8;

    logic                  CLK;
    logic                  RST;
    logic [NREQ-1:0]       req_ren;
    logic [NREQ-1:0]       req_wen;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0][31:0] req_store;
    logic [NREQ-1:0]       req_wait;
    logic [NREQ-1:0][31:0] req_load;
    logic                  ramREN;
    logic                  ramWEN;
    logic [31:0]           ramaddr;
    logic [31:0]           ramstore;
    logic [31:0]           ramload;
    ramstate_t             ramstate;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.NREQ(NREQ), .MAXBEATS(MAXBEATS)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int  m_owner = -1;   // -1: nobody holds the port
    int  m_ptr   = 0;
    int  m_words = 0;
    bit  m_valid = 0;

    always @(negedge CLK) begin
        logic [NREQ-1:0]       e_wait;
        logic [NREQ-1:0][31:0] e_load;
        logic                  e_ren, e_wen, served, own_act;
        logic [31:0]           e_addr, e_store;
        e_wait = '1; e_load = '0; e_ren = 1'b0; e_wen = 1'b0;
        e_addr = 32'h0; e_store = 32'h0; served = 1'b0; own_act = 1'b0;
        if (m_owner >= 0) own_act = req_ren[m_owner] | req_wen[m_owner];
        if (own_act) begin
            e_addr = req_addr[m_owner];
            if (req_wen[m_owner]) begin
                e_wen = 1'b1; e_store = req_store[m_owner];
            end else begin
                e_ren = 1'b1;
            end
            if (ramstate == ACCESS) begin
                served = 1'b1;
                e_wait[m_owner] = 1'b0;
                if (!req_wen[m_owner]) e_load[m_owner] = ramload;
            end
        end
        if (m_valid) begin
            checks++;
            if (req_wait !== e_wait || req_load !== e_load || ramREN !== e_ren ||
                ramWEN !== e_wen || ramaddr !== e_addr || ramstore !== e_store) begin
                failures++;
                $display("FAIL model t=%0t wait=%b/%b ren=%b/%b wen=%b/%b addr=%h/%h store=%h/%h load=%h/%h (got/exp)",
                         $time, req_wait, e_wait, ramREN, e_ren, ramWEN, e_wen,
                         ramaddr, e_addr, ramstore, e_store, req_load, e_load);
            end
        end
        // advance the model to the state after the coming edge
        if (RST) begin
            m_owner = -1; m_ptr = 0; m_words = 0; m_valid = 1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (m_owner < 0 && (req_ren[j] | req_wen[j])) begin
                    m_owner = j; m_words = 0;
                end
            end
        end else if (!own_act) begin
            m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_words = 0;
        end else if (served) begin
            m_words++;
            if (m_words == MAXBEATS) begin
                m_ptr = (m_owner + 1) % NREQ; m_owner = -1; m_words = 0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_reqs();
        req_ren = '0; req_wen = '0; req_addr = '0; req_store = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        ramstate = FREE; ramload = 32'h0;
        RST = 1'b1;
        step(); step();
        RST = 1'b0;
    endtask

    function automatic int served_idx(input logic [NREQ-1:0] w);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (!w[i] && r < 0) r = i;
        return r;
    endfunction

    // ---------------- stimulus ----------------
    int exp_rr[6]     = '{0, 1, 3, 0, 1, 3};
    int exp_burst[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};

    initial begin
        int               q[$];
        logic [NREQ-1:0]  served_prev;
        logic [NREQ-1:0][31:0] exp_ld;
        int               rem[NREQ];
        int               rem1;
        bit               done0;

        // Reset with every requester asking.
        RST = 1'b1; ramstate = FREE; ramload = 32'h0;
        req_wen = '0; req_store = '0;
        req_ren = '1;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 32'h1000 + 32'(i) * 32'h10;
        step();
        @(negedge CLK);
        check("rst_wait", 128'(req_wait), 128'(4'b1111));
        check("rst_en", 128'({ramREN, ramWEN}), 128'(2'b00));
        check("rst_addr", 128'(ramaddr), 128'(32'h0));
        step();
        RST = 1'b0;
        @(negedge CLK);
        check("rst_rel_idle", 128'(ramREN), 128'(1'b0));
        step();
        @(negedge CLK);
        check("rst_grant0_ren", 128'(ramREN), 128'(1'b1));
        check("rst_grant0_addr", 128'(ramaddr), 128'(32'h1000));

        // Single read from requester 2.
        do_reset();
        req_ren[2] = 1'b1; req_addr[2] = 32'h0000_0040;
        ramstate = BUSY; ramload = 32'hDEAD_BEEF;
        @(negedge CLK);
        check("rd_idle_wait", 128'(req_wait), 128'(4'b1111));
        step();
        @(negedge CLK);
        check("rd_addr", 128'(ramaddr), 128'(32'h40));
        check("rd_ren", 128'({ramREN, ramWEN}), 128'(2'b10));
        step(); step();
        ramstate = ACCESS;
        @(negedge CLK);
        exp_ld = '0; exp_ld[2] = 32'hDEAD_BEEF;
        check("rd_wait_drop", 128'(req_wait), 128'(4'b1011));
        check("rd_load", 128'(req_load), 128'(exp_ld));
        step();
        req_ren[2] = 1'b0; ramstate = FREE;
        @(negedge CLK);
        check("rd_drop_en", 128'({ramREN, ramWEN}), 128'(2'b00));
        step();
        req_ren = '1;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 32'h200 + 32'(i) * 32'h10;
        @(negedge CLK);
        check("rd_gap_wait", 128'(req_wait), 128'(4'b1111));
        step();
        @(negedge CLK);
        check("rd_rrptr3", 128'(ramaddr), 128'(32'h230));

        // Round-robin among 0,1,3 with single-word accesses.
        do_reset();
        ramstate = ACCESS;
        served_prev = '0;
        q.delete();
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < NREQ; i++)
                req_ren[i] = (i != 2) && !served_prev[i];
            @(negedge CLK);
            served_prev = ~req_wait;
            if (served_idx(req_wait) >= 0) q.push_back(served_idx(req_wait));
            step();
        end
        for (int i = 0; i < 6; i++)
            check($sformatf("rr_order%0d", i), 128'(i < q.size() ? q[i] : -1), 128'(exp_rr[i]));

        // Burst limit: requester 1 streams 10 words, requester 0 waits.
        do_reset();
        ramstate = ACCESS;
        served_prev = '0; rem1 = 10; done0 = 0;
        req_addr[1] = 32'h8000; req_addr[0] = 32'h4000;
        q.delete();
        for (int c = 0; c < 40; c++) begin
            if (served_prev[1]) begin rem1--; req_addr[1] = req_addr[1] + 32'd4; end
            if (served_prev[0]) done0 = 1;
            req_ren[1] = (rem1 > 0);
            req_ren[0] = (c >= 1) && !done0;
            ramload = $urandom;
            @(negedge CLK);
            served_prev = ~req_wait;
            if (served_idx(req_wait) >= 0) q.push_back(served_idx(req_wait));
            step();
        end
        check("burst_count", 128'(q.size()), 128'(11));
        for (int i = 0; i < 11; i++)
            check($sformatf("burst_order%0d", i), 128'(i < q.size() ? q[i] : -1), 128'(exp_burst[i]));

        // Write wins over read; completion returns no load data.
        do_reset();
        req_ren[0] = 1'b1; req_wen[0] = 1'b1;
        req_addr[0] = 32'h100; req_store[0] = 32'h1234_5678;
        ramstate = BUSY; ramload = 32'hCAFE_F00D;
        step();
        @(negedge CLK);
        check("wr_en", 128'({ramREN, ramWEN}), 128'(2'b01));
        check("wr_store", 128'(ramstore), 128'(32'h1234_5678));
        check("wr_addr", 128'(ramaddr), 128'(32'h100));
        step();
        ramstate = ACCESS;
        @(negedge CLK);
        check("wr_wait", 128'(req_wait), 128'(4'b1110));
        check("wr_load", 128'(req_load), 128'(0));
        step();
        clear_reqs();

        // Abort: owner drops its request while RAM reports ACCESS.
        do_reset();
        req_ren[1] = 1'b1; req_addr[1] = 32'h500; req_addr[2] = 32'h600;
        ramstate = BUSY;
        step();
        @(negedge CLK);
        check("ab_ren", 128'(ramREN), 128'(1'b1));
        step();
        req_ren[1] = 1'b0; ramstate = ACCESS;
        @(negedge CLK);
        check("ab_wait", 128'(req_wait), 128'(4'b1111));
        check("ab_en", 128'({ramREN, ramWEN}), 128'(2'b00));
        step();
        req_ren[1] = 1'b1; req_ren[2] = 1'b1;
        @(negedge CLK);
        check("ab_idle", 128'(ramREN), 128'(1'b0));
        step();
        @(negedge CLK);
        check("ab_next_owner", 128'(ramaddr), 128'(32'h600));

        // Randomised traffic, checked by the model every cycle.
        do_reset();
        served_prev = '0;
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            RST = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (served_prev[i] && rem[i] > 0) begin
                    rem[i]--;
                    req_addr[i]  = req_addr[i] + 32'd4;
                    req_store[i] = $urandom;
                end
                if (rem[i] > 0 && $urandom_range(0, 63) == 0) rem[i] = 0;
                if (rem[i] == 0 && $urandom_range(0, 5) == 0) begin
                    rem[i]       = $urandom_range(1, 12);
                    req_addr[i]  = $urandom & 32'hFFFF_FFFC;
                    req_store[i] = $urandom;
                    req_wen[i]   = $urandom_range(0, 1);
                    req_ren[i]   = req_wen[i] ? ($urandom_range(0, 1) == 1) : 1'b1;
                end
                if (rem[i] == 0) begin
                    req_ren[i] = 1'b0; req_wen[i] = 1'b0;
                end
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: ramstate = ACCESS;
                4, 5:       ramstate = BUSY;
                6, 7:       ramstate = FREE;
                default:    ramstate = ERROR;
            endcase
            ramload = $urandom;
            @(negedge CLK);
            served_prev = ~req_wait;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Round-robin arbiter that shares the single RAM port between `NREQ` cache-side requesters (icache/dcache ports of every core) ahead of the coherence controller's RAM path. It grants one requester at a time, forwards that requester's read/write word accesses to RAM, and returns the per-word `ramstate == ACCESS` handshake as a deasserted wait. A grant is held across multi-word block transfers up to a beat limit, then rotated for fairness.

## Interface
- `NREQ`, 4: number of requesters (≥2).
- `MAXBEATS`, 8: maximum completed word accesses per grant before forced rotation (≥1).
- `CLK`  input  1  rising-edge clock.
- `RST`  input  1  synchronous, active-high reset.
- `req_ren`  input  NREQ  per-requester read request (level, held until served).
- `req_wen`  input  NREQ  per-requester write request (level).
- `req_addr`  input  NREQ×32  per-requester word address.
- `req_store`  input  NREQ×32  per-requester write data.
- `req_wait`  output  NREQ  1 = not served this cycle; 0 for exactly the cycle the owner's access completes.
- `req_load`  output  NREQ×32  read data; valid only when matching `req_wait` is 0, else 0.
- `ramREN`, `ramWEN`  output  1  RAM read/write enable.
- `ramaddr`, `ramstore`  output  32  RAM address / write data.
- `ramload`  input  32  RAM read data.
- `ramstate`  input  ramstate_t  FREE/BUSY/ACCESS/ERROR from `cpu_types_pkg`.

## Operation
- Registered state: `state` ∈ {IDLE, OWN}, `owner` (log2 NREQ), `rr_ptr` (log2 NREQ), `beats` (log2(MAXBEATS)+1).
- Active request of i: `req_ren[i] | req_wen[i]`. If both set, write wins (ramWEN=1, ramREN=0).
- IDLE: all outputs at defaults. If any active request, winner = first active index scanning `rr_ptr, rr_ptr+1, … mod NREQ`; next cycle `state=OWN`, `owner=winner`, `beats=0`. No request: stay.
- OWN: combinationally drive `ramaddr=req_addr[owner]`, `ramstore=req_store[owner]` (write) else 0, `ramREN/ramWEN` from owner's request. Other requesters see `req_wait=1`, `req_load=0`.
- On `ramstate==ACCESS` with owner active: `req_wait[owner]=0`; `req_load[owner]=ramload` for reads, 0 for writes; `beats` increments.
- Requester advances `req_addr` in the cycle after its wait drops to stream the next word; grant persists.
- Release to IDLE (next cycle) when: owner has no active request in OWN; or an ACCESS completes with `beats+1 == MAXBEATS`. On release `rr_ptr = owner+1 mod NREQ`, `beats=0`.
- ERROR and BUSY/FREE: treated as not-yet-complete; keep driving, wait stays 1.
- Owner deasserting request mid-access: RAM enables drop the same cycle (combinational), any ACCESS that cycle is ignored (no wait drop, no beat), release next cycle.

## Timing
- Reset (RST high at edge): `state=IDLE`, `owner=0`, `rr_ptr=0`, `beats=0`. Outputs: `req_wait` all 1, `req_load` all 0, `ramREN=ramWEN=0`, `ramaddr=ramstore=0`. RST mid-transfer aborts immediately; RAM enables low the cycle after the reset edge.
- Arbitration latency: request at cycle N in IDLE → RAM enables at cycle N+1.
- Word latency: RAM latency only; wait drops combinationally in the ACCESS cycle.
- Release costs one IDLE cycle before the next grant (gap of 1 between owners).
- Simultaneous requests: resolved only by `rr_ptr`; index order never fixed.
- `rr_ptr` wraps NREQ-1 → 0. `beats` never exceeds MAXBEATS.
- Max wait for a continuously active requester: (NREQ-1)×(MAXBEATS beats + 1 idle cycle) grants.

## Test plan
- Reset: assert RST 2 cycles with all requests high → all `req_wait`=1, `ramREN=ramWEN=0`, `ramaddr=0`; after release requester 0 granted at cycle+1.
- Single read: req 2 reads 0x0000_0040, RAM ACCESS after 3 cycles with ramload 0xDEAD_BEEF → `req_wait[2]=0` one cycle, `req_load[2]=0xDEADBEEF`, others 0; rr_ptr=3 after drop.
- Round-robin: reqs 0,1,3 held with single-word accesses from reset → grant order 0,1,3,0,… with one IDLE cycle between each.
- Burst limit: MAXBEATS=8, req 1 streams 10 words while req 0 waits → 8 ACCESS completions to 1, release, req 0 granted, req 1 resumes after req 0.
- Write priority and data: req 0 asserts ren+wen, addr 0x100, store 0x1234_5678 → ramWEN=1, ramREN=0, ramstore=0x12345678, `req_load[0]=0` on completion.
- Abort: owner drops request while ramstate=ACCESS → no wait drop, beats unchanged, IDLE next cycle, RAM enables low same cycle.
